// File: rtl/rx_link_supervisor.sv
// rx_link_supervisor: sequencing controller for the pulse-ID receiver.
// Holds the receiver in reset, waits for LOCK_COUNT consecutive well-formed
// pulses to declare lock, forwards qualified pulses while locked and forces
// a resync when too many consecutive intervals are bad or silent.
// Optional macro RX_SUPERVISOR_BACKOFF_EN: doubles the reset hold length
// after every acquisition timeout (capped at HOLD_CYCLES << 6).
module rx_link_supervisor #(
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned ACQ_TIMEOUT  = 50000000,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned TRIG_TIMEOUT = 5000000,
  parameter int unsigned MAX_MISSES   = 3
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        resync_i,
  input  logic        trigger_i,
  input  logic [63:0] pulse_id_i,
  input  logic        error_i,
  output logic        rx_reset_o,
  output logic        locked_o,
  output logic        pulse_valid_o,
  output logic [63:0] pulse_id_o,
  output logic [7:0]  resync_count_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        trigger_q;
  logic        err_flag, err_flag_next;
  logic [63:0] ref_id, ref_id_next;
  logic [31:0] good_cnt, good_cnt_next;
  logic [31:0] miss_cnt, miss_cnt_next;
  logic [31:0] timer, timer_next;
  logic        pulse_valid_next;
  logic [63:0] pulse_id_next;
  logic [7:0]  resync_count_next;
  logic [31:0] hold_len;
  logic        edge_det;
  logic        good_interval;
  logic        force_resync;

  // trigger_q resets high so a trigger already high out of reset is not a pulse
  assign edge_det      = trigger_i & ~trigger_q;
  // An interval is good when the ID advances by exactly one (64-bit wrap
  // included) and no receiver error was seen since the previous edge.
  assign good_interval = (pulse_id_i == ref_id + 64'd1) && !err_flag;

`ifdef RX_SUPERVISOR_BACKOFF_EN
  logic [2:0] bo, bo_next;
  logic       lock_hit;
  logic       acq_timeout_hit;

  assign hold_len        = 32'(HOLD_CYCLES) << bo;
  assign lock_hit        = (state == ST_ACQUIRE) && (state_next == ST_LOCKED);
  // A resync request that coincides with the timeout wins, so no backoff step
  assign acq_timeout_hit = (state == ST_ACQUIRE) && (state_next == ST_HOLD) && !resync_i;

  // Backoff exponent: grows on acquisition timeouts, cleared once lock is reached
  always_comb begin
    bo_next = bo;
    if (lock_hit) begin
      bo_next = 3'd0;
    end else if (acq_timeout_hit && (bo != 3'd6)) begin
      bo_next = bo + 3'd1;
    end
  end

  // Backoff exponent register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bo <= 3'd0;
    end else begin
      bo <= bo_next;
    end
  end
`else
  assign hold_len = 32'(HOLD_CYCLES);
`endif

  // Next-state logic: one shared timer serves as hold, acquire and trigger timer
  always_comb begin
    state_next        = state;
    timer_next        = timer + 32'd1;
    ref_id_next       = ref_id;
    good_cnt_next     = good_cnt;
    miss_cnt_next     = miss_cnt;
    err_flag_next     = error_i | (err_flag & ~edge_det);
    pulse_valid_next  = 1'b0;
    pulse_id_next     = pulse_id_o;
    resync_count_next = resync_count_o;
    force_resync      = resync_i;

    case (state)
      ST_HOLD: begin
        if (timer >= hold_len - 32'd1) begin
          state_next = ST_ACQUIRE;
          timer_next = 32'd0;
        end
      end
      ST_ACQUIRE: begin
        if (edge_det) begin
          ref_id_next = pulse_id_i;
          // good_cnt == 0 marks the first edge since HOLD: it only seeds ref_id
          if ((good_cnt != 32'd0) && good_interval) begin
            good_cnt_next = good_cnt + 32'd1;
            if (good_cnt + 32'd1 >= LOCK_COUNT) begin
              state_next       = ST_LOCKED;
              timer_next       = 32'd0;
              miss_cnt_next    = 32'd0;
              pulse_valid_next = 1'b1;
              pulse_id_next    = pulse_id_i;
            end
          end else begin
            good_cnt_next = 32'd1;
          end
        end else if (timer >= ACQ_TIMEOUT - 32'd1) begin
          state_next = ST_HOLD;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          ref_id_next      = pulse_id_i;
          timer_next       = 32'd0;
          pulse_valid_next = 1'b1;
          pulse_id_next    = pulse_id_i;
          if (good_interval) begin
            miss_cnt_next = 32'd0;
          end else begin
            miss_cnt_next = miss_cnt + 32'd1;
          end
        end else if (timer >= TRIG_TIMEOUT - 32'd1) begin
          timer_next    = 32'd0;
          miss_cnt_next = miss_cnt + 32'd1;
        end
        if (miss_cnt_next >= MAX_MISSES) begin
          force_resync = 1'b1;
        end
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase

    // A resync drops the pulse of the same cycle: the link is being torn down,
    // so nothing is forwarded from the cycle HOLD is entered onwards.
    if (force_resync) begin
      state_next       = ST_HOLD;
      pulse_valid_next = 1'b0;
      pulse_id_next    = pulse_id_o;
      if (resync_count_o != 8'hFF) begin
        resync_count_next = resync_count_o + 8'd1;
      end
    end

    // While holding, all link history is discarded; (re)entry restarts the hold
    if (state_next == ST_HOLD) begin
      if ((state != ST_HOLD) || force_resync) begin
        timer_next = 32'd0;
      end
      ref_id_next   = 64'd0;
      good_cnt_next = 32'd0;
      miss_cnt_next = 32'd0;
      err_flag_next = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= ST_HOLD;
      trigger_q      <= 1'b1;
      err_flag       <= 1'b0;
      ref_id         <= 64'd0;
      good_cnt       <= 32'd0;
      miss_cnt       <= 32'd0;
      timer          <= 32'd0;
      pulse_valid_o  <= 1'b0;
      pulse_id_o     <= 64'd0;
      resync_count_o <= 8'd0;
    end else begin
      state          <= state_next;
      trigger_q      <= trigger_i;
      err_flag       <= err_flag_next;
      ref_id         <= ref_id_next;
      good_cnt       <= good_cnt_next;
      miss_cnt       <= miss_cnt_next;
      timer          <= timer_next;
      pulse_valid_o  <= pulse_valid_next;
      pulse_id_o     <= pulse_id_next;
      resync_count_o <= resync_count_next;
    end
  end

  assign rx_reset_o = (state == ST_HOLD);
  assign locked_o   = (state == ST_LOCKED);
  assign state_o    = state;

endmodule

// File: tb/tb_rx_link_supervisor.sv
// Testbench for rx_link_supervisor: directed table of pulses with hand-derived
// expectations, multi-cycle corner sequences, and randomized traffic checked
// every cycle against a behavioural model of the link rules.
module tb_rx_link_supervisor;

  localparam int HOLD  = 50;
  localparam int ACQ   = 400;
  localparam int LOCKN = 4;
  localparam int TRIG  = 300;
  localparam int MAXM  = 3;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        resync;
  logic        trigger;
  logic [63:0] pid_in;
  logic        error;
  logic        rx_reset;
  logic        locked;
  logic        pulse_valid;
  logic [63:0] pulse_id;
  logic [7:0]  resync_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  rx_link_supervisor #(
    .HOLD_CYCLES (HOLD),
    .ACQ_TIMEOUT (ACQ),
    .LOCK_COUNT  (LOCKN),
    .TRIG_TIMEOUT(TRIG),
    .MAX_MISSES  (MAXM)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .resync_i      (resync),
    .trigger_i     (trigger),
    .pulse_id_i    (pid_in),
    .error_i       (error),
    .rx_reset_o    (rx_reset),
    .locked_o      (locked),
    .pulse_valid_o (pulse_valid),
    .pulse_id_o    (pulse_id),
    .resync_count_o(resync_count),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  int          m_mode;      // 0 hold, 1 acquire, 2 locked
  int          m_in_mode;   // cycles spent in current hold / acquire phase
  int          m_since;     // cycles since last edge (or timeout) while locked
  bit          m_prev;
  bit          m_have_ref;
  logic [63:0] m_ref;
  int          m_streak;
  int          m_miss;
  bit          m_err;
  int          m_resyncs;
  bit          m_valid;
  logic [63:0] m_pid;
  int          m_bo;

  function automatic int m_hold_len();
`ifdef RX_SUPERVISOR_BACKOFF_EN
    return HOLD << m_bo;
`else
    return HOLD;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_in_mode = 0; m_since = 0; m_prev = 1'b1;
    m_have_ref = 1'b0; m_ref = '0; m_streak = 0; m_miss = 0; m_err = 1'b0;
    m_resyncs = 0; m_valid = 1'b0; m_pid = '0; m_bo = 0;
  endtask

  task automatic model_step(input bit trig, input logic [63:0] id, input bit err, input bit rs);
    bit          ev;
    bit          good;
    bit          drop;
    bit          cand_valid;
    logic [63:0] cand_pid;
    ev = trig && !m_prev;
    m_prev = trig;
    good = m_have_ref && (id == m_ref + 64'd1) && !m_err;
    m_err = err || (m_err && !ev);
    cand_valid = 1'b0;
    cand_pid = m_pid;
    drop = rs;
    if (!rs) begin
      if (m_mode == 0) begin
        m_in_mode++;
        if (m_in_mode >= m_hold_len()) begin m_mode = 1; m_in_mode = 0; end
      end else if (m_mode == 1) begin
        m_in_mode++;
        if (ev) begin
          m_streak = good ? m_streak + 1 : 1;
          m_have_ref = 1'b1;
          m_ref = id;
          if (m_streak >= LOCKN) begin
            m_mode = 2; m_since = 0; m_miss = 0; m_bo = 0;
            cand_valid = 1'b1; cand_pid = id;
          end
        end else if (m_in_mode >= ACQ) begin
          m_mode = 0; m_in_mode = 0;
          if (m_bo < 6) m_bo++;
        end
      end else begin
        m_since++;
        if (ev) begin
          cand_valid = 1'b1; cand_pid = id; m_since = 0; m_ref = id;
          m_miss = good ? 0 : m_miss + 1;
        end else if (m_since >= TRIG) begin
          m_since = 0; m_miss++;
        end
        if (m_miss >= MAXM) drop = 1'b1;
      end
    end
    if (drop) begin
      m_mode = 0; m_in_mode = 0;
      if (m_resyncs < 255) m_resyncs++;
      cand_valid = 1'b0; cand_pid = m_pid;
    end
    if (m_mode == 0) begin
      m_have_ref = 1'b0; m_ref = '0; m_streak = 0; m_miss = 0; m_err = 1'b0;
    end
    m_valid = cand_valid;
    m_pid = cand_pid;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_state", 64'(state), 64'(m_mode));
    check("model_rx_reset", 64'(rx_reset), 64'(m_mode == 0));
    check("model_locked", 64'(locked), 64'(m_mode == 2));
    check("model_pulse_valid", 64'(pulse_valid), 64'(m_valid));
    check("model_pulse_id", pulse_id, m_pid);
    check("model_resync_count", 64'(resync_count), 64'(m_resyncs));
  endtask

  // Advance one clock: model consumes the inputs the DUT samples at this edge
  task automatic cycle();
    if (reset_ni) model_step(trigger, pid_in, error, resync);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Trigger low for three cycles (optional error strobe mid-interval), then rise
  task automatic send_pulse(input logic [63:0] id, input bit err, input bit rs);
    trigger = 1'b0; error = 1'b0;
    cycle();
    error = err;
    cycle();
    error = 1'b0;
    cycle();
    trigger = 1'b1; pid_in = id; resync = rs;
    cycle();
    resync = 1'b0;
    $display("pulse id=%0h err=%0b rs=%0b -> valid=%0b id_o=%0h locked=%0b state=%0d rc=%0d",
             id, err, rs, pulse_valid, pulse_id, locked, state, resync_count);
  endtask

  task automatic wait_acquire();
    int n;
    n = 0;
    while (state == 2'd0 && n < 5000) begin cycle(); n++; end
    check("wait_acquire_bound", 64'(n < 5000), 64'd1);
  endtask

  task automatic measure_hold(input string name, input int exp);
    int n;
    n = 0;
    while (rx_reset && n < 10000) begin cycle(); n++; end
    check(name, 64'(n), 64'(exp));
    $display("hold %s measured %0d cycles", name, n);
  endtask

  typedef struct {
    logic [63:0] id;
    bit          err;
    bit          rs;
    bit          meas;
    bit          exp_valid;
    bit          exp_locked;
    logic [1:0]  exp_state;
    logic [7:0]  exp_rc;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic [63:0] id, input bit err, input bit rs, input bit meas,
                              input bit v, input bit l, input logic [1:0] s, input logic [7:0] rc);
    row_t r;
    r.id = id; r.err = err; r.rs = rs; r.meas = meas;
    r.exp_valid = v; r.exp_locked = l; r.exp_state = s; r.exp_rc = rc;
    return r;
  endfunction

  initial begin
    int          n;
    int          exp_hold;
    logic [63:0] next_id;
    bit          rise;

    // Lock from reset with ids 10..13
    rows.push_back(mk(64'd10, 0, 0, 0, 0, 0, 2'd1, 8'd0));
    rows.push_back(mk(64'd11, 0, 0, 0, 0, 0, 2'd1, 8'd0));
    rows.push_back(mk(64'd12, 0, 0, 0, 0, 0, 2'd1, 8'd0));
    rows.push_back(mk(64'd13, 0, 0, 0, 1, 1, 2'd2, 8'd0));
    // Locked with gaps in the id sequence: every edge is strobed, lock held
    rows.push_back(mk(64'd20, 0, 0, 0, 1, 1, 2'd2, 8'd0));
    rows.push_back(mk(64'd21, 0, 0, 0, 1, 1, 2'd2, 8'd0));
    rows.push_back(mk(64'd23, 0, 0, 0, 1, 1, 2'd2, 8'd0));
    rows.push_back(mk(64'd24, 0, 0, 0, 1, 1, 2'd2, 8'd0));
    // Three consecutive error intervals force a resync on the third edge
    rows.push_back(mk(64'd25, 1, 0, 0, 1, 1, 2'd2, 8'd0));
    rows.push_back(mk(64'd26, 1, 0, 0, 1, 1, 2'd2, 8'd0));
    rows.push_back(mk(64'd27, 1, 0, 1, 0, 0, 2'd0, 8'd1));
    // Wrapping ids; resync on the would-be lock edge wins
    rows.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 2'd1, 8'd1));
    rows.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 2'd1, 8'd1));
    rows.push_back(mk(64'd0,                   0, 0, 0, 0, 0, 2'd1, 8'd1));
    rows.push_back(mk(64'd1,                   0, 1, 1, 0, 0, 2'd0, 8'd2));
    // Wrapping ids lock normally
    rows.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 2'd1, 8'd2));
    rows.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 2'd1, 8'd2));
    rows.push_back(mk(64'd0,                   0, 0, 0, 0, 0, 2'd1, 8'd2));
    rows.push_back(mk(64'd1,                   0, 0, 0, 1, 1, 2'd2, 8'd2));

    reset_ni = 1'b0; resync = 1'b0; trigger = 1'b0; error = 1'b0; pid_in = '0;
    model_reset();
    repeat (3) cycle();
    check("reset_rx_reset", 64'(rx_reset), 64'd1);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_pulse_valid", 64'(pulse_valid), 64'd0);
    check("reset_pulse_id", pulse_id, 64'd0);
    check("reset_resync_count", 64'(resync_count), 64'd0);
    check("reset_state", 64'(state), 64'd0);

    // Trigger high out of reset must not count as an edge
    trigger = 1'b1;
    reset_ni = 1'b1;
    measure_hold("hold_after_reset", HOLD);

    foreach (rows[i]) begin
      wait_acquire();
      send_pulse(rows[i].id, rows[i].err, rows[i].rs);
      check($sformatf("row%0d_valid", i), 64'(pulse_valid), 64'(rows[i].exp_valid));
      check($sformatf("row%0d_locked", i), 64'(locked), 64'(rows[i].exp_locked));
      check($sformatf("row%0d_state", i), 64'(state), 64'(rows[i].exp_state));
      check($sformatf("row%0d_rc", i), 64'(resync_count), 64'(rows[i].exp_rc));
      if (rows[i].exp_valid) check($sformatf("row%0d_pid", i), pulse_id, rows[i].id);
      if (rows[i].meas) measure_hold($sformatf("row%0d_hold", i), HOLD);
    end

    // Triggers stop while locked: three trigger timeouts force a resync
    trigger = 1'b0;
    n = 0;
    while (state == 2'd2 && n < 2000) begin cycle(); n++; end
    $display("silence: resync after %0d cycles, state=%0d rc=%0d", n, state, resync_count);
    check("silence_cycles", 64'(n), 64'(3 * TRIG));
    check("silence_state", 64'(state), 64'd0);
    check("silence_rc", 64'(resync_count), 64'd3);

    // Randomized traffic against the model
    next_id = 64'd1000;
    for (int c = 0; c < 20000; c++) begin
      rise = 1'b0;
      if ((c % 4000) >= 3000) trigger = 1'b0;
      else if (trigger) trigger = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else if ($urandom_range(0, 7) == 0) begin trigger = 1'b1; rise = 1'b1; end
      if (rise) begin
        if ($urandom_range(0, 499) == 0) next_id = 64'hFFFF_FFFF_FFFF_FFFD;
        pid_in = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : next_id;
        next_id = pid_in + 64'd1;
      end else begin
        pid_in = {$urandom, $urandom};
      end
      error = ($urandom_range(0, 149) == 0);
      resync = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    resync = 1'b0; error = 1'b0;
    $display("random phase done: rc=%0d state=%0d", resync_count, state);

    // Force a clean lock, then assert reset asynchronously mid-cycle
    resync = 1'b1; cycle(); resync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_acquire();
      send_pulse(64'd500 + 64'(k), 1'b0, 1'b0);
    end
    check("relock_locked", 64'(locked), 64'd1);
    check("relock_pid", pulse_id, 64'd503);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_reset_rx_reset", 64'(rx_reset), 64'd1);
    check("async_reset_locked", 64'(locked), 64'd0);
    check("async_reset_valid", 64'(pulse_valid), 64'd0);
    check("async_reset_pid", pulse_id, 64'd0);
    check("async_reset_rc", 64'(resync_count), 64'd0);
    check("async_reset_state", 64'(state), 64'd0);
    model_reset();
    trigger = 1'b0;
    repeat (2) cycle();
    reset_ni = 1'b1;

    // No triggers: successive hold lengths (growing only with backoff enabled)
    for (int i = 0; i < 8; i++) begin
`ifdef RX_SUPERVISOR_BACKOFF_EN
      exp_hold = HOLD << ((i < 6) ? i : 6);
`else
      exp_hold = HOLD;
`endif
      measure_hold($sformatf("idle_hold%0d", i), exp_hold);
      n = 0;
      while (!rx_reset && n < 2000) begin cycle(); n++; end
      check($sformatf("idle_acq%0d", i), 64'(n), 64'(ACQ));
    end
    check("idle_rc", 64'(resync_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_link_supervisor.md
Name: rx_link_supervisor

Overview:
Sequencing controller for the embedded pulse-ID receiver. It drives the receiver reset and judges link quality from the trigger, pulse-ID and error outputs. It declares lock only after consecutive well-formed pulses and forces a resync when the link degrades. It sits between the receiver and downstream pulse consumers, and replaces the plain error watchdog.

Parameters:
HOLD_CYCLES, 50, receiver reset hold length in clk_i cycles (1 us at 50 MHz)
ACQ_TIMEOUT, 50000000, max cycles in ACQUIRE before re-reset (1 s)
LOCK_COUNT, 4, consecutive good pulses required to declare lock (>=2)
TRIG_TIMEOUT, 5000000, max cycles between triggers while LOCKED (100 ms)
MAX_MISSES, 3, consecutive bad intervals in LOCKED that force resync (>=1)

Ports:
clk_i  in  1  system clock (50 MHz)
reset_ni  in  1  asynchronous active-low reset
resync_i  in  1  synchronous single-cycle request to re-reset receiver
trigger_i  in  1  receiver trigger (level; rising edge = pulse event)
pulse_id_i  in  64  receiver pulse-ID, valid in the cycle trigger_i rises
error_i  in  1  receiver error strobe
rx_reset_o  out  1  receiver reset, active high
locked_o  out  1  link locked
pulse_valid_o  out  1  one-cycle qualified pulse strobe
pulse_id_o  out  64  pulse-ID qualified by pulse_valid_o
resync_count_o  out  8  number of forced resyncs, saturating at 255
state_o  out  2  0 HOLD, 1 ACQUIRE, 2 LOCKED

Behaviour:
- Interface: one clock, clk_i. Reset reset_ni is asynchronous and active-low. All other logic is synchronous to clk_i.
- Reset values: state HOLD, rx_reset_o=1, locked_o=0, pulse_valid_o=0, pulse_id_o=0, resync_count_o=0. All internal counters and flags are 0.
- Edge detect: edge = trigger_i & ~trigger_q. trigger_q resets to 1, so a high level out of reset is not an edge.
- Interval: the span between consecutive edges. err_flag is set by error_i on any cycle, including the edge cycle, and cleared at each edge.
- An interval is good when pulse_id_i == ref_id+1 (mod 2^64, so all-ones -> 0 is consecutive) and err_flag is 0.
- HOLD:
  - rx_reset_o=1 for the hold length, then go to ACQUIRE.
  - On entry: clear ref_id, good_cnt, miss_cnt and err_flag.
- ACQUIRE:
  - rx_reset_o=0.
  - First edge: ref_id<=pulse_id_i, good_cnt=1.
  - Later edge, good interval: good_cnt++. Bad interval: good_cnt=1.
  - ref_id updates on every edge.
  - When good_cnt reaches LOCK_COUNT: go to LOCKED. That same edge produces pulse_valid_o.
  - Cycle counter reaches ACQ_TIMEOUT: go to HOLD. resync_count_o is not incremented.
- LOCKED:
  - locked_o=1.
  - Every edge produces pulse_valid_o=1 and pulse_id_o=pulse_id_i in the next cycle (latency 1, registered), whether the interval is good or bad.
  - Good edge: miss_cnt=0, restart trigger timer.
  - Bad edge, or trigger timer reaches TRIG_TIMEOUT: miss_cnt++ and restart the timer.
  - miss_cnt reaching MAX_MISSES: go to HOLD and increment resync_count_o.
- resync_i in any state: go to HOLD and increment resync_count_o. Priority is resync_i > edge > timeouts.
- A simultaneous edge and timer expiry is evaluated as an edge only.
- locked_o deasserts in the cycle HOLD is entered. pulse_valid_o is never asserted outside LOCKED, except for the lock-completing edge.
- Asserting reset_ni mid-operation returns all outputs to their reset values immediately.
- Timers are 32-bit. Parameters must fit within that width.

Optional Feature:
RX_SUPERVISOR_BACKOFF_EN
- Defined:
  - Hold length = HOLD_CYCLES << bo, with bo a 3-bit counter.
  - bo increments on each ACQUIRE timeout and caps at 6.
  - bo clears on entering LOCKED and on reset_ni.
  - resync_i and LOCKED-miss resyncs use the current bo.
- Undefined: hold length is always HOLD_CYCLES and no bo register exists.

Test Plan:
- Reset release, ids 10,11,12,13 on edges, no errors -> rx_reset_o high exactly 50 cycles. locked_o rises 1 cycle after the 4th edge, together with pulse_valid_o and pulse_id_o=13.
- Locked, ids 20,21,23,24 -> the 23 edge is bad (miss_cnt=1). 24 is good, miss_cnt back to 0. Lock is held and all four ids are strobed.
- Locked, error_i pulses inside 3 consecutive intervals -> HOLD after the 3rd edge, resync_count_o=1, rx_reset_o=1 for 50 cycles.
- Locked, triggers stop -> resync at cycle 15000000 after the last edge (3 timeouts), with state_o 2 -> 0.
- Ids 0xFFFFFFFFFFFFFFFE, 0xFFFFFFFFFFFFFFFF, 0, 1 -> lock achieved (wrap counts as consecutive). resync_i on the same cycle as the lock-completing edge -> HOLD with no pulse_valid_o.
- RX_SUPERVISOR_BACKOFF_EN, no triggers -> successive holds of 50, 100, 200, ..., 3200, 3200 cycles. resync_count_o stays 0.
